// File: rtl/path_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : path_seq_pkg
// Description : Shared types and constants for the path-job sequencer.
//               Holds the FSM state enum, the default data-memory addresses
//               of the start/end points and the node-index width.
//               The TIMEOUT state exists only when PATH_SEQ_WATCHDOG_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
package path_seq_pkg;

   localparam int NODE_W = 5;

   localparam logic [31:0] PATH_SP_ADDR = 32'h0200_0000;
   localparam logic [31:0] PATH_EP_ADDR = 32'h0200_0004;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_SP = 3'd1,
      ST_LOAD_EP = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RUN     = 3'd4,
      ST_DONE    = 3'd5
`ifdef PATH_SEQ_WATCHDOG_EN
      ,
      ST_TIMEOUT = 3'd6
`endif
   } path_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/path_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : path_seq_timer
// Description : Saturating 32-bit RUN-cycle counter with optional watchdog
//               compare (compiled in when PATH_SEQ_WATCHDOG_EN is defined).
// Ports       : clk     - clock
//               reset   - synchronous active-high reset
//               clear   - zero the counter (new job accepted)
//               enable  - count this cycle (FSM in RUN)
//               count   - registered cycle count
//               expired - count has reached TIMEOUT_CYCLES-1 (0 when the
//                         watchdog is not compiled in)
// Revision    : 1.0 - initial release
// ============================================================================
module path_seq_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        enable,
   output logic [31:0] count,
   output logic        expired
);

   logic [31:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= 32'd0;
      end else if (clear) begin
         r_count <= 32'd0;
      end else if (enable && (r_count != 32'hFFFF_FFFF)) begin
         r_count <= r_count + 32'd1;
      end
   end

   assign count = r_count;

`ifdef PATH_SEQ_WATCHDOG_EN
   // Limit reached on the cycle whose increment brings the count to
   // TIMEOUT_CYCLES, so the FSM leaves RUN with count == TIMEOUT_CYCLES.
   localparam logic [31:0] C_LIMIT = 32'(TIMEOUT_CYCLES - 1);

   assign expired = (r_count == C_LIMIT);
`else
   logic w_unused_cfg;

   assign w_unused_cfg = ^TIMEOUT_CYCLES;
   assign expired      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/path_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : path_job_sequencer
// Description : Runs one path-planning job on the RISC-V core: holds the CPU
//               in reset, writes start/end nodes into data memory through the
//               external write port, releases reset and counts RUN cycles
//               until path_found (or the watchdog, when PATH_SEQ_WATCHDOG_EN
//               is defined).
// Ports       : clk, reset (sync, active-high)
//               start, SP, EP      - job request and its node indices
//               path_found         - CPU completion flag
//               reset_cpu          - CPU reset, low only while running
//               Ext_MemWrite/Ext_WriteData/Ext_DataAdr - memory write port
//               busy, done, timeout, cycle_count - job status
// Revision    : 1.0 - initial release
// ============================================================================
module path_job_sequencer
   import path_seq_pkg::*;
#(
   parameter logic [31:0] SP_ADDR        = PATH_SP_ADDR,
   parameter logic [31:0] EP_ADDR        = PATH_EP_ADDR,
   parameter int unsigned RESET_HOLD     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [NODE_W-1:0] SP,
   input  logic [NODE_W-1:0] EP,
   input  logic              path_found,
   output logic              reset_cpu,
   output logic              Ext_MemWrite,
   output logic [31:0]       Ext_WriteData,
   output logic [31:0]       Ext_DataAdr,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [31:0]       cycle_count
);

   localparam logic [7:0] C_HOLD_INIT = 8'(RESET_HOLD - 1);

   path_seq_state_t   r_state;
   path_seq_state_t   w_next_state;
   logic              w_accept;
   logic              w_can_start;
   logic [NODE_W-1:0] r_sp;
   logic [NODE_W-1:0] r_ep;
   logic [7:0]        r_hold_cnt;
   logic              r_reset_cpu;
   logic              r_mem_write;
   logic [31:0]       r_wdata;
   logic [31:0]       r_adr;
   logic              r_busy;
   logic              r_done;
   logic              w_expired;
   logic              w_run;

   assign w_run = (r_state == ST_RUN);

`ifdef PATH_SEQ_WATCHDOG_EN
   assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                        (r_state == ST_TIMEOUT);
`else
   assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE);
`endif

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      if (w_can_start) begin
         if (start) begin
            w_accept     = 1'b1;
            w_next_state = ST_LOAD_SP;
         end
      end else begin
         case (r_state)
            ST_LOAD_SP: w_next_state = ST_LOAD_EP;
            ST_LOAD_EP: w_next_state = ST_HOLD;
            ST_HOLD: begin
               if (r_hold_cnt == 8'd0) w_next_state = ST_RUN;
            end
            ST_RUN: begin
               // path_found has priority over the watchdog on the limit cycle
               if (path_found) w_next_state = ST_DONE;
`ifdef PATH_SEQ_WATCHDOG_EN
               else if (w_expired) w_next_state = ST_TIMEOUT;
`endif
            end
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_sp        <= '0;
         r_ep        <= '0;
         r_hold_cnt  <= 8'd0;
         r_reset_cpu <= 1'b1;
         r_mem_write <= 1'b0;
         r_wdata     <= 32'd0;
         r_adr       <= 32'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_next_state;

         if (w_accept) begin
            r_sp <= SP;
            r_ep <= EP;
         end

         if (r_state == ST_LOAD_EP) begin
            r_hold_cnt <= C_HOLD_INIT;
         end else if ((r_state == ST_HOLD) && (r_hold_cnt != 8'd0)) begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
         end

         // Write port is a registered decode of the current state, so each
         // strobe appears for exactly the one cycle after its LOAD state.
         r_mem_write <= 1'b0;
         r_wdata     <= 32'd0;
         r_adr       <= 32'd0;
         if (r_state == ST_LOAD_SP) begin
            r_mem_write <= 1'b1;
            r_adr       <= SP_ADDR;
            r_wdata     <= {{(32 - NODE_W){1'b0}}, r_sp};
         end else if (r_state == ST_LOAD_EP) begin
            r_mem_write <= 1'b1;
            r_adr       <= EP_ADDR;
            r_wdata     <= {{(32 - NODE_W){1'b0}}, r_ep};
         end

         // CPU released only once RUN is established and stays in RUN;
         // reasserted on the same edge that leaves RUN.
         r_reset_cpu <= !(w_run && (w_next_state == ST_RUN));

         r_busy <= (w_next_state == ST_LOAD_SP) || (w_next_state == ST_LOAD_EP) ||
                   (w_next_state == ST_HOLD)    || (w_next_state == ST_RUN);
         r_done <= (w_next_state == ST_DONE);
      end
   end

   path_seq_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_accept),
      .enable  (w_run),
      .count   (cycle_count),
      .expired (w_expired)
   );

`ifdef PATH_SEQ_WATCHDOG_EN
   logic r_timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= (w_next_state == ST_TIMEOUT);
      end
   end

   assign timeout = r_timeout;
`else
   logic w_unused_expired;

   assign w_unused_expired = w_expired;
   assign timeout          = 1'b0;
`endif

   assign reset_cpu     = r_reset_cpu;
   assign Ext_MemWrite  = r_mem_write;
   assign Ext_WriteData = r_wdata;
   assign Ext_DataAdr   = r_adr;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_path_job_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_path_job_sequencer
// Description : Scoreboard bench for path_job_sequencer. Stimulus tasks push
//               expected memory writes and job completions into queues; a
//               negedge monitor pops and compares whenever the DUT strobes a
//               write or raises done/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_path_job_sequencer;
   import path_seq_pkg::*;

   localparam int unsigned RESET_HOLD     = 4;
   localparam int unsigned TIMEOUT_CYCLES = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  SP;
   logic [4:0]  EP;
   logic        path_found;
   logic        reset_cpu;
   logic        Ext_MemWrite;
   logic [31:0] Ext_WriteData;
   logic [31:0] Ext_DataAdr;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [31:0] cycle_count;

   typedef struct {
      int          at;
      logic [31:0] adr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int          at;
      logic        dn;
      logic        to;
      logic [31:0] cnt;
   } job_t;

   wr_t  wq[$];
   job_t jq[$];

   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic prev_fin = 1'b0;

   path_job_sequencer #(
      .SP_ADDR        (32'h0200_0000),
      .EP_ADDR        (32'h0200_0004),
      .RESET_HOLD     (RESET_HOLD),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .SP            (SP),
      .EP            (EP),
      .path_found    (path_found),
      .reset_cpu     (reset_cpu),
      .Ext_MemWrite  (Ext_MemWrite),
      .Ext_WriteData (Ext_WriteData),
      .Ext_DataAdr   (Ext_DataAdr),
      .busy          (busy),
      .done          (done),
      .timeout       (timeout),
      .cycle_count   (cycle_count)
   );

   always #5 clk = ~clk;

   // cyc holds the index of the most recent rising edge
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every write strobe and every job completion against
   // the head of the matching expectation queue.
   always @(negedge clk) begin
      wr_t  w;
      job_t j;
      if (Ext_MemWrite === 1'b1) begin
         if (wq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: adr=0x%0h data=0x%0h at cycle %0d, none expected",
                     Ext_DataAdr, Ext_WriteData, cyc);
         end else begin
            w = wq.pop_front();
            check("wr_cycle", 32'(cyc), 32'(w.at));
            check("wr_addr", Ext_DataAdr, w.adr);
            check("wr_data", Ext_WriteData, w.data);
         end
      end
      if ((done || timeout) && !prev_fin) begin
         if (jq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_end: done=%b timeout=%b at cycle %0d, none expected",
                     done, timeout, cyc);
         end else begin
            j = jq.pop_front();
            check("end_cycle", 32'(cyc), 32'(j.at));
            check("end_done", 32'(done), 32'(j.dn));
            check("end_timeout", 32'(timeout), 32'(j.to));
            check("end_count", cycle_count, j.cnt);
            check("end_reset_cpu", 32'(reset_cpu), 32'd1);
            check("end_busy", 32'(busy), 32'd0);
         end
      end
      prev_fin = done || timeout;
   end

   // pf > 0 : path_found sampled on the pf-th RUN edge (expected count = pf)
   // pf <= 0: never asserted, watchdog must fire
   // poke   : re-request start with different nodes while the job is busy
   task automatic run_job(input logic [4:0] sp, input logic [4:0] ep,
                          input int pf, input logic poke);
      int          e0;
      int          fin;
      int          n;
      logic        exp_to;
      logic [31:0] exp_cnt;
      @(negedge clk);
      SP    = sp;
      EP    = ep;
      start = 1'b1;
      e0    = cyc + 1;
      if (pf > 0) begin
         exp_to  = 1'b0;
         exp_cnt = 32'(pf);
      end else begin
         exp_to  = 1'b1;
         exp_cnt = 32'(TIMEOUT_CYCLES);
      end
      fin = e0 + 2 + int'(RESET_HOLD) + int'(exp_cnt);
      wq.push_back('{e0 + 1, 32'h0200_0000, {27'd0, sp}});
      wq.push_back('{e0 + 2, 32'h0200_0004, {27'd0, ep}});
      jq.push_back('{fin, !exp_to, exp_to, exp_cnt});
      @(negedge clk);
      check("busy_after_start", 32'(busy), 32'd1);
      check("count_cleared", cycle_count, 32'd0);
      if (poke) begin
         SP    = 5'd9;
         EP    = 5'd9;
         start = 1'b1;
         while (cyc < e0 + 4) @(negedge clk);
      end
      start = 1'b0;
      while (cyc < e0 + 2 + int'(RESET_HOLD)) @(negedge clk);
      check("cpu_held_in_hold", 32'(reset_cpu), 32'd1);
      if (pf == 1) path_found = 1'b1;
      @(negedge clk);
      check("cpu_release", 32'(reset_cpu), (pf == 1) ? 32'd1 : 32'd0);
      path_found = 1'b0;
      if (pf > 1) begin
         while (cyc < fin - 1) @(negedge clk);
         path_found = 1'b1;
         @(negedge clk);
         path_found = 1'b0;
      end
      n = 0;
      while (!(done || timeout) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!(done || timeout)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL job_end_wait: done/timeout still low after 200 cycles, expected completion");
      end
      repeat (3) @(negedge clk);
      check("count_frozen", cycle_count, exp_cnt);
      check("cpu_held_after", 32'(reset_cpu), 32'd1);
   endtask

   // Reset asserted while the FSM sits in HOLD
   task automatic abort_in_hold(input logic [4:0] sp, input logic [4:0] ep);
      int e0;
      @(negedge clk);
      SP    = sp;
      EP    = ep;
      start = 1'b1;
      e0    = cyc + 1;
      wq.push_back('{e0 + 1, 32'h0200_0000, {27'd0, sp}});
      wq.push_back('{e0 + 2, 32'h0200_0004, {27'd0, ep}});
      @(negedge clk);
      start = 1'b0;
      while (cyc < e0 + 3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_reset_cpu", 32'(reset_cpu), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_memwrite", 32'(Ext_MemWrite), 32'd0);
      check("abort_count", cycle_count, 32'd0);
      repeat (10) @(negedge clk);
      check("abort_cpu_stays_reset", 32'(reset_cpu), 32'd1);
      check("abort_idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      path_found = 1'b0;
      SP         = 5'd0;
      EP         = 5'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("rst_reset_cpu", 32'(reset_cpu), 32'd1);
      check("rst_memwrite", 32'(Ext_MemWrite), 32'd0);
      check("rst_wdata", Ext_WriteData, 32'd0);
      check("rst_adr", Ext_DataAdr, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_count", cycle_count, 32'd0);

      // path_found while idle must not end anything
      path_found = 1'b1;
      repeat (3) @(negedge clk);
      path_found = 1'b0;
      check("idle_pf_done", 32'(done), 32'd0);
      check("idle_pf_busy", 32'(busy), 32'd0);

      run_job(5'd3, 5'd17, 10, 1'b0);
      run_job(5'd5, 5'd5, 1, 1'b0);
      run_job(5'd12, 5'd30, 6, 1'b1);
      abort_in_hold(5'd7, 5'd8);
      run_job(5'd21, 5'd4, 3, 1'b0);
      run_job(5'd31, 5'd0, int'(TIMEOUT_CYCLES), 1'b0);
`ifdef PATH_SEQ_WATCHDOG_EN
      run_job(5'd1, 5'd2, 0, 1'b0);
      check("wd_done_low", 32'(done), 32'd0);
`endif

      repeat (4) @(negedge clk);
      check("wr_queue_drained", 32'(wq.size()), 32'd0);
      check("job_queue_drained", 32'(jq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/path_job_sequencer.md
# path_job_sequencer

Sequences one path-planning job on the pipelined RISC-V core. On a start request it holds the CPU in reset, writes the start and end points into data memory over the external write port, releases reset, and counts cycles until the CPU signals `path_found` or a watchdog expires. It sits beside the CPU/memory top and drives the external-write and CPU-reset controls that the top muxes onto the data-memory port.

## Interface
Parameters:
- `SP_ADDR`, default 32'h0200_0000: data-memory byte address of the start point.
- `EP_ADDR`, default 32'h0200_0004: data-memory byte address of the end point.
- `RESET_HOLD`, default 4: cycles `reset_cpu` stays high after the last write. Legal range 1..255.
- `TIMEOUT_CYCLES`, default 1_000_000: RUN-cycle limit, used only when the watchdog is compiled in.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: job request, sampled only in IDLE/DONE/TIMEOUT.
- `SP`  in  5: start node, captured on accepted `start`.
- `EP`  in  5: end node, captured on accepted `start`.
- `path_found`  in  1: CPU completion flag.
- `reset_cpu`  out  1: holds the CPU in reset while high.
- `Ext_MemWrite`  out  1: external data-memory write strobe.
- `Ext_WriteData`  out  32: write data, zero-extended node.
- `Ext_DataAdr`  out  32: write address.
- `busy`  out  1: job in progress (LOAD_SP..RUN).
- `done`  out  1: level signal, job ended with `path_found`.
- `timeout`  out  1: level signal, watchdog expired.
- `cycle_count`  out  32: RUN cycles of the current or last job.

## Operation
- States: IDLE, LOAD_SP, LOAD_EP, HOLD, RUN, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + `start` -> LOAD_SP:
  - Latch SP/EP.
  - Clear `done`, `timeout` and `cycle_count`.
  - Later changes on SP/EP have no effect until the next accepted start.
- LOAD_SP: `Ext_MemWrite`=1, `Ext_DataAdr`=SP_ADDR, `Ext_WriteData`={27'b0,SP_latched}. Next state: LOAD_EP.
- LOAD_EP: the same with EP_ADDR and EP_latched. Next state: HOLD, with the hold counter loaded to RESET_HOLD-1.
- HOLD: counter decrements. At 0 -> RUN.
- RUN:
  - `reset_cpu`=0.
  - `cycle_count` increments by 1 per cycle and saturates at 32'hFFFF_FFFF.
  - `path_found` -> DONE.
  - Watchdog: `cycle_count`==TIMEOUT_CYCLES-1 without `path_found` -> TIMEOUT.
- DONE/TIMEOUT: `reset_cpu`=1 again. `cycle_count` frozen. Flag held until the next start or `reset`.
- `reset_cpu`=1 in every state except RUN.
- `Ext_MemWrite`=0 outside LOAD_SP/LOAD_EP. `Ext_DataAdr`/`Ext_WriteData` = 0 outside those states.
- Boundary conditions:
  - `start` while busy: ignored.
  - SP==EP: still a normal job.
  - `path_found` outside RUN: ignored.
  - `path_found` on the watchdog-limit cycle: DONE wins.
  - `path_found` already high on the first RUN cycle: DONE after that one cycle, `cycle_count`=1.
  - `reset` mid-job: IDLE next edge, all outputs at reset values, no partial write repeated.

## Timing
- Reset values: `reset_cpu`=1, `Ext_MemWrite`=0, `Ext_WriteData`=0, `Ext_DataAdr`=0, `busy`=0, `done`=0, `timeout`=0, `cycle_count`=0, state=IDLE.
- All outputs registered, with no combinational input-to-output paths.
- Cycle schedule, where edge 0 samples `start`:
  - After edge 1: SP write visible.
  - After edge 2: EP write visible.
  - HOLD occupies RESET_HOLD cycles.
  - `reset_cpu` falls after edge 2+RESET_HOLD+1.
- `path_found` sampled at edge k in RUN: `done`=1 and `reset_cpu`=1 after edge k.
- Each write strobe lasts exactly 1 cycle. The external side is a memory port with no backpressure.

## Configuration
- `PATH_SEQ_WATCHDOG_EN` defined: the watchdog compare and the TIMEOUT state are compiled in, and `timeout` is functional.
- Not defined:
  - No compare logic and no TIMEOUT state.
  - RUN waits indefinitely for `path_found`.
  - `timeout` tied to 0 and `TIMEOUT_CYCLES` unused.

## Structure
- Package `path_seq_pkg`:
  - State enum `path_seq_state_t`.
  - Default address constants `PATH_SP_ADDR` and `PATH_EP_ADDR`.
  - Constant `NODE_W`=5.
- Sub-module `path_seq_timer`:
  - Saturating 32-bit RUN counter plus the watchdog compare (the compare is inside the macro guard).
  - Inputs: `clk`, `reset`, `clear`, `enable`.
  - Outputs: `count`, `expired`.
- The FSM and the write-port registers stay in the top module.

## Test plan
- Reset, then SP=3, EP=17, `start` pulse, RESET_HOLD=4:
  - Write (0x0200_0000, 3) on cycle 1.
  - Write (0x0200_0004, 17) on cycle 2.
  - `reset_cpu` falls after edge 7.
- In RUN, assert `path_found` after 10 RUN cycles -> `done`=1, `cycle_count`=10, `reset_cpu`=1, `busy`=0.
- With the watchdog enabled and TIMEOUT_CYCLES=20, never assert `path_found` -> `timeout`=1 after 20 RUN cycles and `done`=0.
- Pulse `start` and change SP during LOAD_EP/HOLD -> no new writes, and the originally latched SP/EP were the ones written.
- Assert `reset` during HOLD -> IDLE next cycle, `reset_cpu`=1, `busy`=0. A subsequent `start` runs a full job.
- `path_found` and the watchdog limit on the same cycle -> `done`=1, `timeout`=0.
